// File: rtl/v15_peak_detector.sv
// v15_peak_detector: threshold-crossing pulse detector reporting peak amplitude, peak time and width.
// Optional macro V15_PILEUP_REJECT_EN: a re-crossing during holdoff discards the pulse and counts pile-up.
module v15_peak_detector #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned HOLDOFF   = 8,
    parameter int unsigned MIN_WIDTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] filter_data,
    input  logic [DATA_W-1:0] threshold,
    input  logic              enable,
    output logic              peak_valid,
    input  logic              peak_ready,
    output logic [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]   peak_time,
    output logic [CNT_W-1:0]  peak_width,
    output logic [CNT_W-1:0]  lost_count,
    output logic              busy
`ifdef V15_PILEUP_REJECT_EN
    ,
    output logic [CNT_W-1:0]  pileup_count
`endif
);

    localparam logic [7:0]       HOLDOFF_C = 8'(HOLDOFF);
    localparam logic [CNT_W-1:0] MIN_W_C   = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABOVE,
        ST_HOLD
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] max_q;
    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   tmax_q;
    logic [CNT_W-1:0]  width_q;
    logic [7:0]        below_cnt;

    logic              above;
    logic              close_pulse;
    logic              emit;
    logic [CNT_W-1:0]  width_inc;
    logic [7:0]        below_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
            ts  <= '0;
        end else begin
            s_q <= filter_data;
            ts  <= ts + 1'b1;
        end
    end

    // Close is decided on the evaluated sample so the result register loads on the same edge.
    always_comb begin
        above       = s_q > threshold;
        width_inc   = (width_q == '1) ? width_q : width_q + 1'b1;
        below_inc   = below_cnt + 8'd1;
        close_pulse = 1'b0;
        if (enable && !above) begin
            if (state == ST_ABOVE) begin
                close_pulse = (HOLDOFF_C == 8'd1);
            end else if (state == ST_HOLD) begin
                close_pulse = (below_inc == HOLDOFF_C);
            end
        end
        emit = close_pulse && (width_q >= MIN_W_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            max_q     <= '0;
            tmax_q    <= '0;
            width_q   <= '0;
            below_cnt <= '0;
            busy      <= 1'b0;
        end else if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (above) begin
                        state     <= ST_ABOVE;
                        max_q     <= s_q;
                        tmax_q    <= ts;
                        width_q   <= ONE_W;
                        below_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_ABOVE: begin
                    if (above) begin
                        width_q <= width_inc;
                        if (s_q > max_q) begin
                            max_q  <= s_q;
                            tmax_q <= ts;
                        end
                    end else if (close_pulse) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= ST_HOLD;
                        below_cnt <= 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (!above) begin
                        if (close_pulse) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            below_cnt <= below_inc;
                        end
                    end else begin
`ifdef V15_PILEUP_REJECT_EN
                        state     <= ST_ABOVE;
                        max_q     <= s_q;
                        tmax_q    <= ts;
                        width_q   <= ONE_W;
                        below_cnt <= '0;
`else
                        state     <= ST_ABOVE;
                        width_q   <= width_inc;
                        below_cnt <= '0;
                        if (s_q > max_q) begin
                            max_q  <= s_q;
                            tmax_q <= ts;
                        end
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef V15_PILEUP_REJECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pileup_count <= '0;
        end else if (enable && state == ST_HOLD && above && pileup_count != '1) begin
            pileup_count <= pileup_count + 1'b1;
        end
    end
`endif

    // A full register that is read in the emit cycle reloads without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_valid <= 1'b0;
            peak_amp   <= '0;
            peak_time  <= '0;
            peak_width <= '0;
            lost_count <= '0;
        end else if (emit) begin
            if (!peak_valid || peak_ready) begin
                peak_valid <= 1'b1;
                peak_amp   <= max_q;
                peak_time  <= tmax_q;
                peak_width <= width_q;
            end else if (lost_count != '1) begin
                lost_count <= lost_count + 1'b1;
            end
        end else if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_v15_peak_detector.sv
// Directed bench for v15_peak_detector (TS_W=8 so timestamp wrap is reachable); table rows plus corner sequences.
module tb_v15_peak_detector;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TS_W   = 8;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] filter_data = '0;
    logic [DATA_W-1:0] threshold = 16'd100;
    logic              enable = 1'b1;
    logic              peak_valid;
    logic              peak_ready = 1'b0;
    logic [DATA_W-1:0] peak_amp;
    logic [TS_W-1:0]   peak_time;
    logic [CNT_W-1:0]  peak_width;
    logic [CNT_W-1:0]  lost_count;
    logic              busy;
`ifdef V15_PILEUP_REJECT_EN
    logic [CNT_W-1:0]  pileup_count;
`endif

    v15_peak_detector #(
        .DATA_W   (DATA_W),
        .TS_W     (TS_W),
        .HOLDOFF  (8),
        .MIN_WIDTH(4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .filter_data(filter_data),
        .threshold  (threshold),
        .enable     (enable),
        .peak_valid (peak_valid),
        .peak_ready (peak_ready),
        .peak_amp   (peak_amp),
        .peak_time  (peak_time),
        .peak_width (peak_width),
        .lost_count (lost_count),
        .busy       (busy)
`ifdef V15_PILEUP_REJECT_EN
        ,
        .pileup_count(pileup_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference timestamp: value the detector should assign to a sample driven now is tb_ts+1.
    logic [TS_W-1:0] tb_ts;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1'b1;
    end

    typedef struct {
        logic [15:0] data;
        logic        rdy;
        logic        mark;
        logic        exp_busy;
        logic        exp_valid;
        logic [15:0] exp_amp;
        logic [15:0] exp_width;
        logic        chk_time;
    } vec_t;

    vec_t            vecs[$];
    int              checks = 0;
    int              errors = 0;
    logic [TS_W-1:0] mark_ts = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] d, input logic r, input logic m, input logic b,
                       input logic v, input logic [15:0] a, input logic [15:0] w, input logic ct);
        vec_t x;
        x.data = d; x.rdy = r; x.mark = m; x.exp_busy = b;
        x.exp_valid = v; x.exp_amp = a; x.exp_width = w; x.chk_time = ct;
        vecs.push_back(x);
    endtask

    task automatic step(input logic [15:0] d);
        filter_data = d;
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] d, input int n);
        for (int k = 0; k < n; k++) step(d);
    endtask

    task automatic sync_ts(input logic [TS_W-1:0] target);
        for (int k = 0; k < 300 && tb_ts != target; k++) step(16'd0);
        check("ts_sync", 32'(tb_ts), 32'(target));
    endtask

    task automatic check_result(input string name, input logic [15:0] a, input logic [15:0] w);
        check({name, "_valid"}, 32'(peak_valid), 32'd1);
        check({name, "_amp"}, 32'(peak_amp), 32'(a));
        check({name, "_width"}, 32'(peak_width), 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Single pulse, then a consumed result, a short pulse and an equal-to-threshold run.
        add(0,   0, 0, 0, 0, 0, 0, 0);
        add(150, 0, 0, 0, 0, 0, 0, 0);
        add(300, 0, 0, 1, 0, 0, 0, 0);
        add(450, 0, 1, 1, 0, 0, 0, 0);
        add(300, 0, 0, 1, 0, 0, 0, 0);
        add(150, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0,   0, 0, 0, 1, 450, 5, 1);
        add(0,   1, 0, 0, 0, 0, 0, 0);
        add(150, 0, 0, 0, 0, 0, 0, 0);
        add(150, 0, 0, 1, 0, 0, 0, 0);
        add(150, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0,   0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(100, 0, 0, 0, 0, 0, 0, 0);
        add(0,   0, 0, 0, 0, 0, 0, 0);

        #1;
        check("rst_valid", 32'(peak_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lost", 32'(lost_count), 32'd0);
        check("rst_amp", 32'(peak_amp), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            filter_data = vecs[i].data;
            peak_ready  = vecs[i].rdy;
            if (vecs[i].mark) mark_ts = tb_ts + 1'b1;
            @(negedge clk);
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("row%0d_valid", i), 32'(peak_valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d_lost", i), 32'(lost_count), 32'd0);
            if (vecs[i].exp_valid) begin
                check($sformatf("row%0d_amp", i), 32'(peak_amp), 32'(vecs[i].exp_amp));
                check($sformatf("row%0d_width", i), 32'(peak_width), 32'(vecs[i].exp_width));
            end
            if (vecs[i].chk_time) check($sformatf("row%0d_time", i), 32'(peak_time), 32'(mark_ts));
        end
        peak_ready = 1'b0;

        // Backpressure: second result dropped, held result unchanged.
        step(200); step(300); step(250); step(200); step(150);
        run(0, 10);
        check_result("bp_first", 300, 5);
        run(400, 4);
        run(0, 10);
        check_result("bp_held", 300, 5);
        check("bp_lost", 32'(lost_count), 32'd1);

        // Ready asserted exactly in the emit cycle; tie at 500 keeps the first time.
        mark_ts = tb_ts + 1'b1;
        step(500);
        run(500, 5);
        run(0, 8);
        check_result("noBubble_pre", 300, 5);
        peak_ready = 1'b1;
        step(0);
        peak_ready = 1'b0;
        check_result("noBubble_load", 500, 6);
        check("noBubble_time", 32'(peak_time), 32'(mark_ts));
        check("noBubble_lost", 32'(lost_count), 32'd1);
        step(0);
        check_result("noBubble_hold", 500, 6);
        peak_ready = 1'b1;
        step(0);
        peak_ready = 1'b0;
        check("consume_valid", 32'(peak_valid), 32'd0);

        // Re-crossing during holdoff.
        run(200, 5); run(0, 3); run(500, 2); run(0, 10);
`ifdef V15_PILEUP_REJECT_EN
        check("pileup_valid", 32'(peak_valid), 32'd0);
        check("pileup_count", 32'(pileup_count), 32'd1);
`else
        check_result("merge", 500, 7);
`endif
        peak_ready = 1'b1;
        step(0);
        peak_ready = 1'b0;

        // Enable dropped mid-pulse.
        run(300, 6);
        check("en_busy_before", 32'(busy), 32'd1);
        enable = 1'b0;
        step(0);
        check("en_busy_after", 32'(busy), 32'd0);
        enable = 1'b1;
        run(0, 10);
        check("en_no_result", 32'(peak_valid), 32'd0);
        check("en_lost", 32'(lost_count), 32'd1);

        // Asynchronous reset mid-pulse.
        run(300, 4);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        filter_data = '0;
        #1;
        check("rstmid_valid", 32'(peak_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_lost", 32'(lost_count), 32'd0);
        check("rstmid_amp", 32'(peak_amp), 32'd0);
        check("rstmid_width", 32'(peak_width), 32'd0);
        check("rstmid_time", 32'(peak_time), 32'd0);
`ifdef V15_PILEUP_REJECT_EN
        check("rstmid_pileup", 32'(pileup_count), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Timestamp wrap: peak at ts=255, then a peak on the wrapped ts=0.
        sync_ts(8'd251);
        step(200); step(300); step(400); step(500); step(400);
        run(0, 10);
        check_result("wrap255", 500, 5);
        check("wrap255_time", 32'(peak_time), 32'd255);
        peak_ready = 1'b1;
        step(0);
        peak_ready = 1'b0;
        sync_ts(8'd252);
        step(200); step(300); step(400); step(500);
        run(0, 10);
        check_result("wrap0", 500, 4);
        check("wrap0_time", 32'(peak_time), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/v15_peak_detector.md
Name: v15_peak_detector

Overview:
- Sits directly downstream of the v15 trapezoidal shaping filter and consumes its output stream, one sample per clock.
- Detects threshold-crossing pulses and extracts, per pulse: peak amplitude, timestamp of the peak and width above threshold.
- Presents each result on a one-deep valid/ready output register for the readout/histogramming stage.

Parameters:
- DATA_W, 16: filter sample width, equal to SIZE_FILTER_DATA; samples are unsigned.
- TS_W, 32: width of the free-running timestamp counter.
- HOLDOFF, 8: number of consecutive at-or-below-threshold samples that closes a pulse; legal range 1..255.
- MIN_WIDTH, 4: minimum above-threshold sample count for a pulse to be reported; shorter pulses are discarded silently.
- CNT_W, 16: width of the width counter and the lost counter; both saturate at their maximum.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- filter_data  in  DATA_W  shaped sample from the filter, valid every cycle.
- threshold  in  DATA_W  detection level, used live.
- enable  in  1  detection enable.
- peak_valid  out  1  result register holds an unread result.
- peak_ready  in  1  consumer accepts the result.
- peak_amp  out  DATA_W  maximum sample of the pulse.
- peak_time  out  TS_W  timestamp of the first occurrence of the maximum.
- peak_width  out  CNT_W  above-threshold sample count.
- lost_count  out  CNT_W  results dropped because the output register was full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0, FSM to IDLE, timestamp counter 0, input register 0.
- Input register: s_q <= filter_data every cycle. The FSM evaluates s_q only.
- Timestamp: ts increments every cycle after reset and wraps at 2^TS_W. The timestamp of s_q is the ts value in the cycle the FSM evaluates s_q.
- "Above" means s_q > threshold, strict comparison. Equality counts as below.
- IDLE:
  - if enable=1 and above: go to ABOVE; max=s_q, tmax=ts, width=1, below_cnt=0.
- ABOVE:
  - above: width+1 (saturating); if s_q > max then max=s_q, tmax=ts. Ties keep the earlier time.
  - below: go to HOLDOFF, below_cnt=1.
- HOLDOFF:
  - below: below_cnt+1. When below_cnt reaches HOLDOFF, close the pulse and go to IDLE. With HOLDOFF=1, the pulse closes on the ABOVE->HOLDOFF sample itself and the FSM goes straight to IDLE.
  - above: re-crossing; handled per the Optional Feature.
- Close:
  - if width >= MIN_WIDTH, emit a result; otherwise discard it silently.
  - Emission latency: peak_valid rises on the second rising edge after the HOLDOFF-th below sample is on filter_data.
- Output register:
  - loads on emit when peak_valid=0, or when peak_valid=1 and peak_ready=1 in the same cycle (accept and reload, no gap).
  - if peak_valid=1, peak_ready=0 and an emit occurs: the new result is dropped and lost_count+1 (saturating). The held result is unchanged.
  - peak_valid clears on peak_valid & peak_ready when no emit occurs that cycle.
  - peak_amp, peak_time and peak_width are stable while peak_valid=1.
- enable=0: the FSM returns to IDLE on the next edge and any in-flight pulse is discarded without counting. The output register, lost_count and ts are unaffected.
- threshold change mid-pulse takes effect on the next evaluated sample.
- busy = (state != IDLE), registered.
- Reset asserted mid-pulse: no result emitted; everything clears immediately.

Optional Feature:
- Macro: V15_PILEUP_REJECT_EN.
- Without the macro, a re-crossing in HOLDOFF merges into the same pulse:
  - back to ABOVE, width+1, max/tmax tracking continues, below_cnt cleared;
  - below samples are not counted in width.
- With the macro, a re-crossing in HOLDOFF is treated as pile-up:
  - the current pulse is discarded;
  - extra output port pileup_count (CNT_W, saturating, reset 0) increments;
  - the FSM enters ABOVE with a fresh pulse: max=s_q, tmax=ts, width=1.

Test Plan:
- Single pulse: threshold=100, HOLDOFF=8, MIN_WIDTH=4; samples 0,150,300,450,300,150,then 0x20 -> one result: amp=450, width=5, peak_time = ts of the 450 sample, peak_valid rises 2 edges after the 8th zero is presented.
- Short pulse and equality: samples 150,150,150 then zeros, plus a run of samples equal to 100 -> no peak_valid, lost_count=0.
- Backpressure: two qualifying pulses with peak_ready=0 -> first result held unchanged, lost_count=1. Then pulse peak_ready exactly in an emit cycle -> new result loads with no bubble.
- Re-crossing: 200x5, 0x3, 500x2, 0x8 -> without macro: one result, amp=500, width=7. With V15_PILEUP_REJECT_EN: pileup_count=1 and a fresh pulse of width 2 that is discarded by MIN_WIDTH, so no result.
- Control: deassert enable mid-pulse -> busy=0 next cycle, no result. Assert reset mid-pulse -> all outputs 0 and ts restarts at 0.
- Timestamp wrap with TS_W=8: pulse peak at ts=255 -> peak_time=255; the next cycle's ts=0.
